// File: rtl/updown_mod_counter.sv
// updown_mod_counter
// One time field of the stopwatch datapath: a modulo-MOD up/down counter
// with synchronous load, pause, per-field adjust, optional saturation and
// a two-digit BCD view of the count. Fields are chained through
// carry_in/carry_out. All state advances on the falling edge of magic_clk.
module updown_mod_counter #(
   parameter int MOD       = 100,
   parameter int W         = 7,
   parameter int SAT       = 0,
   parameter int RESET_VAL = 0
) (
   input  logic         magic_clk,
   input  logic         reset,
   input  logic         tick_en,
   input  logic         carry_in,
   input  logic         dir,
   input  logic         adj,
   input  logic         adj_sel,
   input  logic         pause,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] count,
   output logic [3:0]   bcd_tens,
   output logic [3:0]   bcd_ones,
   output logic         carry_out,
   output logic         done
);

   // Terminal values and the reset value, all held at the counter width.
   localparam logic [W-1:0] MAX_C  = W'(MOD - 1);
   localparam logic [W-1:0] ZERO_C = {W{1'b0}};
   localparam logic [W-1:0] ONE_C  = W'(1);
   localparam logic [W-1:0] RST_C  = W'(RESET_VAL);
   localparam logic         SAT_EN = (SAT != 0);

   // Ones digit of a binary value below 100, by repeated compare-and-subtract.
   function automatic logic [3:0] bcd_ones_f(input logic [W-1:0] v);
      logic [6:0] rem;
      rem = 7'(v);
      for (int i = 0; i < 9; i++) begin
         if (rem >= 7'd10) begin
            rem = rem - 7'd10;
         end else begin
            rem = rem;
         end
      end
      return 4'(rem);
   endfunction

   // Tens digit of a binary value below 100, by the same comparator chain.
   function automatic logic [3:0] bcd_tens_f(input logic [W-1:0] v);
      logic [6:0] rem;
      logic [3:0] tens;
      rem  = 7'(v);
      tens = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (rem >= 7'd10) begin
            rem  = rem - 7'd10;
            tens = tens + 4'd1;
         end else begin
            rem  = rem;
            tens = tens;
         end
      end
      return tens;
   endfunction

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         done_q;
   logic         done_d;
   logic [W-1:0] step_val_s;
   logic         at_top_s;
   logic         at_bot_s;
   logic         at_term_s;
   logic         step_s;

   // Terminal detection and the value one step away in the current direction.
   always_comb begin
      at_top_s   = (count_q == MAX_C);
      at_bot_s   = (count_q == ZERO_C);
      at_term_s  = 1'b0;
      step_val_s = count_q;
      if (dir) begin
         at_term_s = at_bot_s;
         if (!at_bot_s) begin
            step_val_s = count_q - ONE_C;
         end else if (SAT_EN) begin
            step_val_s = ZERO_C;
         end else begin
            step_val_s = MAX_C;
         end
      end else begin
         at_term_s = at_top_s;
         if (!at_top_s) begin
            step_val_s = count_q + ONE_C;
         end else if (SAT_EN) begin
            step_val_s = MAX_C;
         end else begin
            step_val_s = ZERO_C;
         end
      end
   end

   // Step qualifier: in adjust mode only the selected field moves and the
   // lower field's carry is irrelevant; otherwise step on tick and carry.
   always_comb begin
      step_s = 1'b0;
      if (adj) begin
         step_s = adj_sel & tick_en;
      end else begin
         step_s = tick_en & carry_in;
      end
   end

   // Next state: load beats pause, pause beats adjust/normal stepping.
   always_comb begin
      count_d = count_q;
      done_d  = done_q;
      if (load) begin
         if (load_value > MAX_C) begin
            count_d = MAX_C;
         end else begin
            count_d = load_value;
         end
         done_d = 1'b0;
      end else if (pause) begin
         count_d = count_q;
         done_d  = done_q;
      end else if (step_s) begin
         count_d = step_val_s;
         if (SAT_EN && at_term_s) begin
            done_d = 1'b1;
         end else begin
            done_d = done_q;
         end
      end else begin
         count_d = count_q;
         done_d  = done_q;
      end
   end

   // Count and done registers, falling-edge clocked with asynchronous reset.
   always_ff @(negedge magic_clk or posedge reset) begin
      if (reset) begin
         count_q <= RST_C;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   // Carry to the next field only on a normal-mode wrap; the next field
   // samples it on the same falling edge so both fields roll together.
   always_comb begin
      carry_out = 1'b0;
      if (!adj && !pause && !load && tick_en && carry_in && at_term_s && !SAT_EN) begin
         carry_out = 1'b1;
      end else begin
         carry_out = 1'b0;
      end
   end

   // Output view of the state, including the display digits.
   always_comb begin
      count    = count_q;
      done     = done_q;
      bcd_tens = bcd_tens_f(count_q);
      bcd_ones = bcd_ones_f(count_q);
   end

endmodule
